lmb_bram_responder: RTL and testbench

//  Slave-side LMB controller that answers MicroBlaze LMB transactions by driving port A of the

---
 rtl/lmb_bram_responder.sv | 124 ++++++++++++
 tb/tb_lmb_bram_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lmb_bram_responder.sv
// LMB slave controller for port A of the local-memory BRAM.
// Decodes the address window, drives BRAM enables/strobes and returns Sl_Ready/Sl_Wait/Sl_UE.
module lmb_bram_responder #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_FFFF,
  parameter int          C_LMB_AWIDTH = 32,
  parameter int          C_LMB_DWIDTH = 32,
  parameter int          C_RD_PIPE    = 0
) (
  input  logic                    LMB_Clk,
  input  logic                    LMB_Rst,
  input  logic [0:C_LMB_AWIDTH-1] LMB_ABus,
  input  logic [0:C_LMB_DWIDTH-1] LMB_WriteDBus,
  input  logic                    LMB_AddrStrobe,
  input  logic                    LMB_ReadStrobe,
  input  logic                    LMB_WriteStrobe,
  input  logic [0:3]              LMB_BE,
  output logic [0:C_LMB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_Ready,
  output logic                    Sl_Wait,
  output logic                    Sl_UE,
  output logic                    BRAM_Rst_A,
  output logic                    BRAM_Clk_A,
  output logic                    BRAM_EN_A,
  output logic [0:3]              BRAM_WEN_A,
  output logic [0:31]             BRAM_Addr_A,
  input  logic [0:C_LMB_DWIDTH-1] BRAM_Din_A,
  output logic [0:C_LMB_DWIDTH-1] BRAM_Dout_A,
  output logic [1:0]              dbg_state
);

  // Handshake: a transaction is offered for exactly one cycle (LMB_AddrStrobe with a
  // read or write qualifier); this slave completes it with a one-cycle Sl_Ready pulse,
  // optionally preceded by a one-cycle Sl_Wait pulse when the read pipe stage is enabled.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    RD_PEND = 2'd2
  } state_t;

  localparam logic [C_LMB_AWIDTH-1:0] BASE    = C_LMB_AWIDTH'(C_BASEADDR);
  localparam logic [C_LMB_AWIDTH-1:0] SPAN_M1 = C_LMB_AWIDTH'(C_HIGHADDR - C_BASEADDR);

  state_t                    state;
  state_t                    state_next;
  logic [C_LMB_AWIDTH-1:0]   offset;
  logic [31:0]               offset32;
  logic                      in_window;
  logic                      accept_state;
  logic                      qualified;
  logic                      is_write;
  logic                      be_legal;
  logic                      hit;
  logic                      resp_write_q;
  logic                      resp_ue_q;
  logic [0:C_LMB_DWIDTH-1]   rd_data_q;
  logic [0:C_LMB_DWIDTH-1]   data_src;

  // Unsigned offset also rejects addresses below the base: they wrap past the span.
  assign offset       = LMB_ABus - BASE;
  assign offset32     = 32'(offset);
  assign in_window    = (offset <= SPAN_M1);
  assign accept_state = (state == IDLE) || (state == RESP);
  assign qualified    = LMB_ReadStrobe | LMB_WriteStrobe;
  assign is_write     = LMB_WriteStrobe;
  assign hit          = LMB_AddrStrobe & qualified & in_window & accept_state & ~LMB_Rst;

  always_comb begin
    be_legal = 1'b0;
    case (LMB_BE)
      4'b1111, 4'b1100, 4'b0011,
      4'b1000, 4'b0100, 4'b0010, 4'b0001: be_legal = 1'b1;
      default:                            be_legal = 1'b0;
    endcase
  end

  assign BRAM_Rst_A  = LMB_Rst;
  assign BRAM_Clk_A  = LMB_Clk;
  assign BRAM_EN_A   = hit;
  assign BRAM_WEN_A  = (hit & is_write & be_legal) ? LMB_BE : 4'b0000;
  assign BRAM_Addr_A = offset32 & ~32'h0000_0003;
  assign BRAM_Dout_A = LMB_WriteDBus;

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE, RESP: begin
        if (hit) begin
          if (is_write || (C_RD_PIPE == 0)) state_next = RESP;
          else                              state_next = RD_PEND;
        end
      end
      RD_PEND: state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge LMB_Clk) begin
    if (LMB_Rst) begin
      state        <= IDLE;
      resp_write_q <= 1'b0;
      resp_ue_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state <= state_next;
      if (hit) begin
        resp_write_q <= is_write;
        resp_ue_q    <= is_write & ~be_legal;
      end
      // BRAM data for the pending read is valid during RD_PEND; capture it for RESP.
      if (state == RD_PEND) rd_data_q <= BRAM_Din_A;
    end
  end

  assign data_src  = (C_RD_PIPE != 0) ? rd_data_q : BRAM_Din_A;
  assign Sl_Ready  = (state == RESP);
  assign Sl_Wait   = (state == RD_PEND);
  assign Sl_UE     = Sl_Ready & resp_ue_q;
  // OR-bus: the data bus must be all-zero unless a read is completing.
  assign Sl_DBus   = (Sl_Ready & ~resp_write_q) ? data_src : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_lmb_bram_responder.sv
// Directed bench: one responder without and one with the read pipe stage, each on its own
// behavioural BRAM, driven by the same LMB stimulus.
module tb_lmb_bram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus;
  logic [0:31] wdata;
  logic        as, rs, ws;
  logic [0:3]  be;

  logic [0:31] s0_dbus, s1_dbus;
  logic        s0_ready, s0_wait, s0_ue, s1_ready, s1_wait, s1_ue;
  logic        b0_rst, b0_clk, b0_en, b1_rst, b1_clk, b1_en;
  logic [0:3]  b0_wen, b1_wen;
  logic [0:31] b0_addr, b1_addr, b0_din, b1_din, b0_dout, b1_dout;
  logic [1:0]  s0_state, s1_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] b2b_vals [4] = '{32'h1100_0044, 32'h0102_0304, 32'hA5A5_5A5A, 32'h0BAD_F00D};

  always #5 clk = ~clk;

  lmb_bram_responder #(.C_RD_PIPE(0)) u_dut0 (
    .LMB_Clk(clk), .LMB_Rst(rst), .LMB_ABus(abus), .LMB_WriteDBus(wdata),
    .LMB_AddrStrobe(as), .LMB_ReadStrobe(rs), .LMB_WriteStrobe(ws), .LMB_BE(be),
    .Sl_DBus(s0_dbus), .Sl_Ready(s0_ready), .Sl_Wait(s0_wait), .Sl_UE(s0_ue),
    .BRAM_Rst_A(b0_rst), .BRAM_Clk_A(b0_clk), .BRAM_EN_A(b0_en), .BRAM_WEN_A(b0_wen),
    .BRAM_Addr_A(b0_addr), .BRAM_Din_A(b0_din), .BRAM_Dout_A(b0_dout), .dbg_state(s0_state)
  );

  lmb_bram_responder #(.C_RD_PIPE(1)) u_dut1 (
    .LMB_Clk(clk), .LMB_Rst(rst), .LMB_ABus(abus), .LMB_WriteDBus(wdata),
    .LMB_AddrStrobe(as), .LMB_ReadStrobe(rs), .LMB_WriteStrobe(ws), .LMB_BE(be),
    .Sl_DBus(s1_dbus), .Sl_Ready(s1_ready), .Sl_Wait(s1_wait), .Sl_UE(s1_ue),
    .BRAM_Rst_A(b1_rst), .BRAM_Clk_A(b1_clk), .BRAM_EN_A(b1_en), .BRAM_WEN_A(b1_wen),
    .BRAM_Addr_A(b1_addr), .BRAM_Din_A(b1_din), .BRAM_Dout_A(b1_dout), .dbg_state(s1_state)
  );

  // Behavioural BRAMs: read-first, one-cycle latency, BE[0] is the most significant byte.
  logic [31:0] a0, a1, d0, d1;
  assign a0 = b0_addr;
  assign a1 = b1_addr;
  assign d0 = b0_dout;
  assign d1 = b1_dout;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    b0_din = '0;
    b1_din = '0;
  end

  always @(posedge clk) begin
    if (b0_en) begin
      b0_din <= mem0[a0[9:2]];
      for (int b = 0; b < 4; b++)
        if (b0_wen[b]) mem0[a0[9:2]][31-8*b -: 8] <= d0[31-8*b -: 8];
    end
  end

  always @(posedge clk) begin
    if (b1_en) begin
      b1_din <= mem1[a1[9:2]];
      for (int b = 0; b < 4; b++)
        if (b1_wen[b]) mem1[a1[9:2]][31-8*b -: 8] <= d1[31-8*b -: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    as = 1'b0; rs = 1'b0; ws = 1'b0; abus = '0; wdata = '0; be = 4'b0000;
  endtask

  task automatic drive_acc(input logic wr, input logic both, input logic [31:0] a,
                           input logic [0:3] b, input logic [31:0] d);
    as = 1'b1; ws = wr; rs = ~wr | both; abus = a; wdata = d; be = b;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [0:3] b, input logic [31:0] d,
                          input logic [0:3] wen_exp, input logic ue_exp, input logic both);
    @(negedge clk);
    drive_acc(1'b1, both, a, b, d);
    #2;
    chk("wr_en0", b0_en, 1);
    chk("wr_wen0", b0_wen, wen_exp);
    chk("wr_addr0", b0_addr, a & ~32'h3);
    chk("wr_dout0", b0_dout, d);
    chk("wr_wen1", b1_wen, wen_exp);
    @(negedge clk);
    drive_idle();
    #2;
    chk("wr_rdy0", s0_ready, 1);
    chk("wr_ue0", s0_ue, ue_exp);
    chk("wr_wait0", s0_wait, 0);
    chk("wr_dbus0", s0_dbus, 0);
    chk("wr_rdy1", s1_ready, 1);
    chk("wr_ue1", s1_ue, ue_exp);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    drive_acc(1'b0, 1'b0, a, 4'b1010, 32'hFFFF_FFFF);
    #2;
    chk("rd_en0", b0_en, 1);
    chk("rd_wen0", b0_wen, 0);
    chk("rd_addr0", b0_addr, a & ~32'h3);
    @(negedge clk);
    drive_idle();
    #2;
    chk("rd_rdy0", s0_ready, 1);
    chk("rd_data0", s0_dbus, exp);
    chk("rd_ue0", s0_ue, 0);
    chk("rd_wait1", s1_wait, 1);
    chk("rd_rdy1_early", s1_ready, 0);
    chk("rd_dbus1_early", s1_dbus, 0);
    @(negedge clk);
    #2;
    chk("rd_rdy0_drop", s0_ready, 0);
    chk("rd_dbus0_drop", s0_dbus, 0);
    chk("rd_rdy1", s1_ready, 1);
    chk("rd_data1", s1_dbus, exp);
    chk("rd_wait1_drop", s1_wait, 0);
  endtask

  initial begin
    drive_idle();
    // Reset: a hit-looking strobe while in reset must not reach the BRAM.
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h10, 4'b1111, 32'h1234_5678);
    #2;
    chk("rst_en0", b0_en, 0);
    chk("rst_wen0", b0_wen, 0);
    chk("rst_en1", b1_en, 0);
    chk("rst_bram_rst", b0_rst, 1);
    @(negedge clk);
    drive_idle();
    #2;
    chk("rst_rdy0", s0_ready, 0);
    chk("rst_wait1", s1_wait, 0);
    chk("rst_ue0", s0_ue, 0);
    chk("rst_dbus0", s0_dbus, 0);
    chk("rst_state1", s1_state, 0);
    rst = 1'b0;

    // Full-word write then read back.
    do_write(32'h10, 4'b1111, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0);
    do_read(32'h10, 32'hDEAD_BEEF);

    // Byte lanes over a zeroed word.
    do_write(32'h0, 4'b1000, 32'h1122_3344, 4'b1000, 1'b0, 1'b0);
    do_write(32'h0, 4'b0001, 32'hAABB_CC44, 4'b0001, 1'b0, 1'b0);
    do_read(32'h0, 32'h1100_0044);

    // Illegal byte enables: no write, UE with Ready.
    do_write(32'h0, 4'b1010, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0);
    do_read(32'h0, 32'h1100_0044);

    // Outside the window: nobody here answers.
    @(negedge clk);
    drive_acc(1'b0, 1'b0, 32'h0001_0000, 4'b1111, 32'h0);
    #2;
    chk("miss_en0", b0_en, 0);
    chk("miss_en1", b1_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle();
      #2;
      chk("miss_rdy0", s0_ready, 0);
      chk("miss_rdy1", s1_ready, 0);
      chk("miss_wait1", s1_wait, 0);
    end

    // Prefill, one write with both strobes high (treated as a write).
    do_write(32'h4, 4'b1111, 32'h0102_0304, 4'b1111, 1'b0, 1'b1);
    do_write(32'h8, 4'b1111, 32'hA5A5_5A5A, 4'b1111, 1'b0, 1'b0);
    do_write(32'hC, 4'b1111, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0);

    // Back-to-back reads every cycle; the piped instance drops strobes seen in RD_PEND.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) drive_acc(1'b0, 1'b0, 32'(4 * i), 4'b1111, 32'h0);
      else       drive_idle();
      #2;
      if (i < 4) chk("b2b_en0", b0_en, 1);
      if (i >= 1) begin
        chk("b2b_rdy0", s0_ready, 1);
        chk("b2b_data0", s0_dbus, exp_q.pop_front());
      end
      if (i < 4) exp_q.push_back(b2b_vals[i]);
      case (i)
        1: begin chk("b2b_wait1_a", s1_wait, 1); chk("b2b_en1_a", b1_en, 0); end
        2: begin chk("b2b_rdy1_a", s1_ready, 1); chk("b2b_data1_a", s1_dbus, b2b_vals[0]);
                 chk("b2b_en1_b", b1_en, 1); end
        3: begin chk("b2b_wait1_b", s1_wait, 1); chk("b2b_en1_c", b1_en, 0); end
        4: begin chk("b2b_rdy1_b", s1_ready, 1); chk("b2b_data1_b", s1_dbus, b2b_vals[2]); end
        default: ;
      endcase
    end
    @(negedge clk);
    #2;
    chk("b2b_end_rdy0", s0_ready, 0);
    chk("b2b_end_rdy1", s1_ready, 0);

    // Reset while the piped instance has a read pending drops the response.
    @(negedge clk);
    drive_acc(1'b0, 1'b0, 32'h8, 4'b1111, 32'h0);
    #2;
    chk("rp_en1", b1_en, 1);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rp_rdy1", s1_ready, 0);
    chk("rp_wait1", s1_wait, 0);
    chk("rp_dbus1", s1_dbus, 0);
    chk("rp_rdy0", s0_ready, 0);
    @(negedge clk);
    #2;
    chk("rp_rdy1_late", s1_ready, 0);
    do_read(32'hC, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
